// File: rtl/prog_loader.sv
// prog_loader: framed byte-stream loader (length, data, checksum) driving the
// program-memory write port, with sticky done/err status.
module prog_loader #(
   parameter int DATA_SIZE = 8,
   parameter int ADDR_SIZE = 4
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 start,
   input  logic [DATA_SIZE-1:0] in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 W,
   output logic [ADDR_SIZE-1:0] ADDR,
   output logic [DATA_SIZE-1:0] DATA_WR,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);
   localparam int unsigned DEPTH = 2**ADDR_SIZE;
   typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
   state_t               r_state, w_next;
   logic [ADDR_SIZE:0]   r_idx, r_len, w_idx_nxt;
   logic [DATA_SIZE-1:0] r_sum, w_sum_nxt, r_data;
   logic [ADDR_SIZE-1:0] r_addr;
   logic                 r_w, w_acc, w_wr, w_len_bad, w_sum_ok, w_begin;
   assign w_acc     = in_valid && in_ready;
   assign w_wr      = w_acc && r_state == S_DATA;
   assign w_begin   = start && !busy;
   assign w_idx_nxt = r_idx + (ADDR_SIZE+1)'(1);
   assign w_sum_nxt = r_sum + in_data;
   assign w_sum_ok  = w_sum_nxt == '0;
   assign w_len_bad = in_data == '0 || 32'(in_data) > DEPTH;
   assign W         = r_w;
   assign ADDR      = r_addr;
   assign DATA_WR   = r_data;
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= S_IDLE;
      else r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE, S_ERR: w_next = start ? S_LEN : r_state;
         S_LEN:  w_next = w_acc ? (w_len_bad ? S_ERR : S_DATA) : S_LEN;
         S_DATA: w_next = (w_acc && w_idx_nxt == r_len) ? S_CSUM : S_DATA;
         S_CSUM: w_next = w_acc ? (w_sum_ok ? S_DONE : S_ERR) : S_CSUM;
         default: w_next = S_IDLE;
      endcase
   end
   always_comb begin
      busy     = r_state == S_LEN || r_state == S_DATA || r_state == S_CSUM;
      in_ready = busy;
      done     = r_state == S_DONE;
      err      = r_state == S_ERR;
   end
   // Index/sum restart on a new frame; write port registers hold while W is low.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_w    <= 1'b0;
         r_addr <= '0;
         r_data <= '0;
         r_idx  <= '0;
         r_len  <= '0;
         r_sum  <= '0;
      end else begin
         r_w <= w_wr;
         if (w_begin) begin
            r_idx <= '0;
            r_sum <= '0;
         end
         if (w_acc && r_state == S_LEN) r_len <= (ADDR_SIZE+1)'(in_data);
         if (w_wr) begin
            r_addr <= r_idx[ADDR_SIZE-1:0];
            r_data <= in_data;
            r_sum  <= w_sum_nxt;
            r_idx  <= w_idx_nxt;
         end
      end
   end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized frames against a frame-level model of the loader.
module tb_prog_loader;
   typedef logic [7:0] bq_t[$];
   logic       clk = 1'b0;
   logic       rstn, start, in_valid, in_ready, W, busy, done, err;
   logic [7:0] in_data, DATA_WR;
   logic [3:0] ADDR;
   int         n_vec = 0, n_err = 0;
   int         wq[$];
   bq_t        f;

   prog_loader #(.DATA_SIZE(8), .ADDR_SIZE(4)) dut (
      .clk(clk), .rstn(rstn), .start(start), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .W(W), .ADDR(ADDR), .DATA_WR(DATA_WR),
      .busy(busy), .done(done), .err(err));

   always #5 clk = ~clk;

   always @(negedge clk) if (W === 1'b1) wq.push_back({20'd0, ADDR, DATA_WR});

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("ready_after_start", {31'd0, in_ready}, 1);
      chk("flags_cleared", {30'd0, done, err}, 0);
   endtask

   task automatic send(input bq_t q, input int pct, input bit mid_start);
      int  i = 0, guard = 0;
      bit  acc;
      while (i < q.size() && guard < 2000) begin
         @(negedge clk);
         in_valid = $urandom_range(99) < pct;
         in_data  = in_valid ? q[i] : 8'($urandom);
         start    = mid_start && i == 2;
         acc      = in_valid && in_ready;
         @(posedge clk);
         if (acc) i++;
         guard++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
      chk("send_complete", i, q.size());
   endtask

   task automatic run_frame(input bq_t q, input int pct, input bit mid_start);
      int         n = q[0];
      bit         len_ok = n >= 1 && n <= 16;
      logic [7:0] s = 8'd0;
      bit         ok = 1'b0;
      wq.delete();
      do_start();
      send(q, pct, mid_start);
      #1;
      if (len_ok) begin
         for (int i = 1; i <= n; i++) s += q[i];
         s += q[n+1];
         ok = s == 8'd0;
      end
      chk("write_count", wq.size(), len_ok ? n : 0);
      for (int i = 0; i < wq.size() && len_ok && i < n; i++)
         chk($sformatf("write[%0d]", i), wq[i], {20'd0, 4'(i), q[i+1]});
      chk("done", {31'd0, done}, {31'd0, ok});
      chk("err", {31'd0, err}, {31'd0, !ok});
      chk("busy_after", {31'd0, busy}, 0);
      chk("w_after", {31'd0, W}, 0);
   endtask

   function automatic bq_t rand_frame();
      bq_t        q;
      int         n = $urandom_range(0, 18);
      logic [7:0] s = 8'd0;
      q.push_back(8'(n));
      if (n >= 1 && n <= 16) begin
         for (int i = 0; i < n; i++) begin
            q.push_back(8'($urandom));
            s += q[i+1];
         end
         q.push_back($urandom_range(99) < 70 ? 8'(-s) : 8'($urandom));
      end
      return q;
   endfunction

   initial begin
      rstn = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {16'd0, in_ready, W, busy, done, err, ADDR}, 0);
      chk("reset_data_wr", {24'd0, DATA_WR}, 0);
      rstn = 1'b1;
      f = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
      run_frame(f, 100, 0);
      f = '{8'h02, 8'hAA, 8'h55, 8'h00};
      run_frame(f, 100, 0);
      f = '{8'h00};
      run_frame(f, 100, 0);
      f = '{8'h11};
      run_frame(f, 100, 0);
      f = '{8'h10};
      for (int i = 0; i < 16; i++) f.push_back(8'h01);
      f.push_back(8'hF0);
      run_frame(f, 100, 0);
      f = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
      run_frame(f, 50, 0);
      run_frame(f, 100, 1);
      f = '{8'h03, 8'h11, 8'h22};
      do_start();
      send(f, 100, 0);
      rstn = 1'b0;
      #1;
      chk("reset_mid_outputs", {16'd0, in_ready, W, busy, done, err, ADDR}, 0);
      chk("reset_mid_data_wr", {24'd0, DATA_WR}, 0);
      @(negedge clk);
      rstn = 1'b1;
      f = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
      run_frame(f, 100, 0);
      for (int k = 0; k < 25; k++) run_frame(rand_frame(), $urandom_range(30, 100), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
